// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate BIST block.
package gate_bist_pkg;

    localparam int NUM_VEC  = 4;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Lowest set bit of a mismatch mask; 0 when the mask is empty.
    function automatic logic [1:0] first_mismatch(input logic [NUM_VEC-1:0] diff);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (diff[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gate_bist_timer.sv
// Loadable down-counter that flags the last cycle of a vector hold.
module gate_bist_timer
    import gate_bist_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_expire
);

    logic [SETTLE_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - SETTLE_W'(1);
        end
    end

    // A count of one means the current edge is the last of the hold.
    assign o_expire = (r_count == SETTLE_W'(1));

endmodule

// File: rtl/gate_bist.sv
// Sweeps all four input vectors of a 2-input gate, captures its truth table
// and compares it against an expected table latched at start.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_VEC-1:0] expected,
    output logic               dut_a,
    output logic               dut_b,
    input  logic               dut_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] captured,
    output logic [1:0]         fail_idx
);

    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);
    localparam logic [1:0]          LAST_VEC = 2'(NUM_VEC - 1);

    state_t             r_state;
    logic [1:0]         r_vec;
    logic [NUM_VEC-1:0] r_exp;
    logic [NUM_VEC-1:0] r_cap;
    logic               r_pass;
    logic [1:0]         r_fail_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_dut_a;
    logic               r_dut_b;

    logic               w_accept;
    logic               w_expire;
    logic               w_load;
    logic               w_dec;
    logic [1:0]         w_vec_next;
    logic [NUM_VEC-1:0] w_cap_next;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_load     = w_accept || ((r_state == SWEEP) && w_expire && (r_vec != LAST_VEC));
    assign w_dec      = (r_state == SWEEP) && !w_load;
    assign w_vec_next = r_vec + 2'd1;

    // Captured table with the current vector's sample merged in.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VEC; gi++) begin : g_cap
            assign w_cap_next[gi] = (r_vec == 2'(gi)) ? dut_y : r_cap[gi];
        end
    endgenerate

    gate_bist_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (SETTLE_V),
        .i_dec      (w_dec),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_vec      <= '0;
            r_exp      <= '0;
            r_cap      <= '0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dut_a    <= 1'b0;
            r_dut_b    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= SWEEP;
                        r_exp      <= expected;
                        r_cap      <= '0;
                        r_pass     <= 1'b0;
                        r_fail_idx <= '0;
                        r_vec      <= '0;
                        r_busy     <= 1'b1;
                        r_dut_a    <= 1'b0;
                        r_dut_b    <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (w_expire) begin
                        r_cap <= w_cap_next;
                        if (r_vec == LAST_VEC) begin
                            // Vector counter holds at the last vector; no wrap.
                            r_state    <= REPORT;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_pass     <= (w_cap_next == r_exp);
                            r_fail_idx <= first_mismatch(w_cap_next ^ r_exp);
                            r_dut_a    <= 1'b0;
                            r_dut_b    <= 1'b0;
                        end else begin
                            r_vec   <= w_vec_next;
                            r_dut_a <= w_vec_next[1];
                            r_dut_b <= w_vec_next[0];
                        end
                    end
                end
                REPORT: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_dut_a <= 1'b0;
                    r_dut_b <= 1'b0;
                end
            endcase
        end
    end

    assign dut_a    = r_dut_a;
    assign dut_b    = r_dut_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign captured = r_cap;
    assign fail_idx = r_fail_idx;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: one instance with SETTLE=1 and one with SETTLE=3 driving
// a gate whose output is only correct on the last cycle of each hold.
module tb_gate_bist;

    logic       clk;
    logic       rst;
    logic       start1, start3;
    logic [3:0] exp1, exp3;
    logic [3:0] tt1, tt3;

    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] cap1;
    logic [1:0] fi1;
    logic       a3, b3, y3, busy3, done3, pass3;
    logic [3:0] cap3;
    logic [1:0] fi3;

    int n_vec = 0;
    int n_mis = 0;
    int sw3   = 0;

    gate_bist #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(exp1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .captured(cap1), .fail_idx(fi1)
    );

    gate_bist #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(exp3),
        .dut_a(a3), .dut_b(b3), .dut_y(y3),
        .busy(busy3), .done(done3), .pass(pass3), .captured(cap3), .fail_idx(fi3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gate models: y3 is inverted except on the 3rd cycle of each 3-cycle hold.
    always @(negedge clk) sw3 <= busy3 ? sw3 + 1 : 0;
    assign y1 = tt1[{a1, b1}];
    assign y3 = tt3[{a3, b3}] ^ ((sw3 % 3) != 0);

    logic       sel;
    logic       m_busy, m_done, m_pass, m_a, m_b;
    logic [3:0] m_cap;
    logic [1:0] m_fi;
    assign m_busy = sel ? busy3 : busy1;
    assign m_done = sel ? done3 : done1;
    assign m_pass = sel ? pass3 : pass1;
    assign m_a    = sel ? a3    : a1;
    assign m_b    = sel ? b3    : b1;
    assign m_cap  = sel ? cap3  : cap1;
    assign m_fi   = sel ? fi3   : fi1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    function automatic logic [1:0] ref_fail_idx(input logic [3:0] cap, input logic [3:0] ex);
        for (int i = 0; i < 4; i++) begin
            if (cap[i] != ex[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // Entered at a negedge with the selected DUT idle; leaves one cycle after done.
    task automatic run_sweep(input logic s, input logic [3:0] tt, input logic [3:0] ex,
                             input logic [3:0] cap_req, input logic pass_req,
                             input logic [1:0] fi_req, input logic chg,
                             input logic [3:0] chg_val, input string nm);
        int S, cyc, busy_n, vec_bad, done_cyc;
        S = s ? 3 : 1;
        sel = s;
        if (s) begin tt3 = tt; exp3 = ex; start3 = 1'b1; end
        else   begin tt1 = tt; exp1 = ex; start1 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        cyc = 1; busy_n = 0; vec_bad = 0; done_cyc = 0;
        while (cyc <= 60 && done_cyc == 0) begin
            if (m_busy) begin
                busy_n++;
                if ({m_a, m_b} != 2'((busy_n - 1) / S)) vec_bad++;
            end
            if (chg && cyc == 2) begin
                if (s) exp3 = chg_val; else exp1 = chg_val;
            end
            if (m_done) done_cyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("%s.done_cycle", nm), done_cyc, 4 * S + 1);
        chk($sformatf("%s.busy_cycles", nm), busy_n, 4 * S);
        chk($sformatf("%s.vector_order", nm), vec_bad, 0);
        chk($sformatf("%s.busy_at_done", nm), m_busy, 0);
        chk($sformatf("%s.ab_at_done", nm), {m_a, m_b}, 0);
        chk($sformatf("%s.captured", nm), m_cap, cap_req);
        chk($sformatf("%s.pass", nm), m_pass, pass_req);
        chk($sformatf("%s.fail_idx", nm), m_fi, fi_req);
        $display("sweep %s settle=%0d: captured=%b pass=%b fail_idx=%0d", nm, S, m_cap, m_pass, m_fi);
        @(negedge clk);
        chk($sformatf("%s.done_pulse_len", nm), m_done, 0);
        chk($sformatf("%s.result_hold", nm), {m_cap, m_pass, m_fi}, {cap_req, pass_req, fi_req});
    endtask

    typedef struct {
        logic       s;
        logic [3:0] tt;
        logic [3:0] ex;
        logic [3:0] cap;
        logic       pass;
        logic [1:0] fi;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] tt, ex;
        logic       s;
        int         dcnt, bcnt;
        logic [10:0] bh, dh, bh_req, dh_req;

        tbl[0] = '{1'b0, 4'b1110, 4'b1110, 4'b1110, 1'b1, 2'd0};
        tbl[1] = '{1'b0, 4'b1110, 4'b1000, 4'b1110, 1'b0, 2'd1};
        tbl[2] = '{1'b1, 4'b1110, 4'b1110, 4'b1110, 1'b1, 2'd0};
        tbl[3] = '{1'b0, 4'b0110, 4'b0111, 4'b0110, 1'b0, 2'd0};
        tbl[4] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd3};
        tbl[5] = '{1'b0, 4'b0111, 4'b0111, 4'b0111, 1'b1, 2'd0};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
        exp1 = '0; exp3 = '0; tt1 = 4'b1110; tt3 = 4'b1110; sel = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        chk("reset.outputs1", {busy1, done1, pass1, cap1, fi1, a1, b1}, 0);
        chk("reset.outputs3", {busy3, done3, pass3, cap3, fi3, a3, b3}, 0);
        start1 = 1'b0;
        rst = 1'b0;

        foreach (tbl[i])
            run_sweep(tbl[i].s, tbl[i].tt, tbl[i].ex, tbl[i].cap, tbl[i].pass, tbl[i].fi,
                      1'b0, 4'b0, $sformatf("tbl%0d", i));

        // Expected table changed mid-sweep must not affect the result.
        run_sweep(1'b0, 4'b1110, 4'b1110, 4'b1110, 1'b1, 2'd0, 1'b1, 4'b0000, "exp_change");

        // Starts during the sweep and on the done cycle are ignored.
        sel = 1'b0; tt1 = 4'b1110; exp1 = 4'b1110;
        start1 = 1'b1; @(negedge clk);
        start1 = 1'b0; @(negedge clk);
        start1 = 1'b1; @(negedge clk);
        start1 = 1'b0;
        dcnt = 0; bcnt = 0;
        for (int k = 0; k < 10 && dcnt == 0; k++) begin
            if (done1) dcnt++; else @(negedge clk);
        end
        chk("ignore.first_done_seen", dcnt, 1);
        start1 = 1'b1; @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done1) dcnt++;
            if (busy1) bcnt++;
            @(negedge clk);
        end
        chk("ignore.done_pulses", dcnt, 1);
        chk("ignore.busy_after", bcnt, 0);
        $display("ignore-start sequence: done pulses=%0d", dcnt);

        // Start held high restarts on the first IDLE cycle after REPORT.
        start1 = 1'b1;
        bh = '0; dh = '0; bh_req = '0; dh_req = '0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            bh[k-1] = busy1;
            dh[k-1] = done1;
            bh_req[k-1] = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
            dh_req[k-1] = (k == 5) || (k == 11);
        end
        start1 = 1'b0;
        chk("held_start.busy_trace", bh, bh_req);
        chk("held_start.done_trace", dh, dh_req);
        $display("held-start sequence: busy=%b done=%b", bh, dh);
        @(negedge clk);

        // Asynchronous reset during vector 10 aborts the sweep.
        tt1 = 4'b1110; exp1 = 4'b1110;
        start1 = 1'b1; @(negedge clk);
        start1 = 1'b0; @(negedge clk);
        @(negedge clk);
        chk("abort.vector_before_rst", {a1, b1}, 2'b10);
        #1 rst = 1'b1;
        #1 chk("abort.outputs_async", {busy1, done1, pass1, cap1, fi1, a1, b1}, 0);
        #1 rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1 || busy1) dcnt++;
        end
        chk("abort.no_done", dcnt, 0);
        $display("abort sequence: activity after reset=%0d", dcnt);
        run_sweep(1'b0, 4'b1110, 4'b1110, 4'b1110, 1'b1, 2'd0, 1'b0, 4'b0, "after_abort");

        // Random gate tables and expected tables against the reference rules.
        for (int r = 0; r < 20; r++) begin
            s  = 1'($urandom_range(0, 1));
            tt = 4'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? tt : 4'($urandom);
            run_sweep(s, tt, ex, tt, (tt == ex), ref_fail_idx(tt, ex), 1'b0, 4'b0,
                      $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter SETTLE, default 1, is the number of clock cycles each input vector is held before the gate output is sampled; the legal range is 1..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request to run one sweep; it is sampled only in IDLE.
REQ-005 Port expected, input, 4 bits: the expected truth table; bit i is the expected output for vector i, where i = {a,b}.
REQ-006 Port dut_a, output, 1 bit: drives the A input of the gate under test; it is the MSB of the vector.
REQ-007 Port dut_b, output, 1 bit: drives the B input of the gate under test; it is the LSB of the vector.
REQ-008 Port dut_y, input, 1 bit: the output of the gate under test.
REQ-009 Port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse at the end of a sweep.
REQ-011 Port pass, output, 1 bit: high when the captured table equals the latched expected table.
REQ-012 Port captured, output, 4 bits: the sampled truth table; bit i is the sample for vector i.
REQ-013 Port fail_idx, output, 2 bits: the lowest vector index that mismatched; it is 0 on pass.

Function
REQ-014 The FSM shall have three states: IDLE, SWEEP and REPORT.
REQ-015 IDLE -> SWEEP on start=1; SWEEP -> REPORT after vector 3 is sampled; REPORT -> IDLE unconditionally after one cycle.
REQ-016 On accepting start at edge t, the block shall latch expected, clear captured/pass/fail_idx, set vector=00, load the settle counter with SETTLE, and set busy=1.
REQ-017 Each vector shall be driven on dut_a/dut_b for exactly SETTLE cycles, in the order 00, 01, 10, 11.
REQ-018 dut_y shall be sampled into captured[vector] on the last edge of the hold; the next vector is driven from that same edge.
REQ-019 Sweep timing: busy shall be high from edge t through edge t+4*SETTLE; REPORT (done=1, busy=0) occupies the cycle after edge t+4*SETTLE.
REQ-020 pass and fail_idx shall be computed from the latched expected table and become valid in the same cycle done=1.
REQ-021 pass, captured and fail_idx shall hold their values until the next accepted start.
REQ-022 In IDLE and REPORT, dut_a and dut_b shall be 0.
REQ-023 start during SWEEP or REPORT shall be ignored; no queuing.
REQ-024 Changes on expected after acceptance shall have no effect on the running sweep.
REQ-025 start held high continuously shall begin a new sweep on the first IDLE cycle after REPORT.
REQ-026 The settle counter shall be 4 bits wide and reload with SETTLE on each vector advance.
REQ-027 The vector counter shall be 2 bits wide; it shall not wrap into a fifth vector.

Reset
REQ-028 While rst=1, regardless of clk: state=IDLE and busy, done, pass, captured, fail_idx, dut_a, dut_b and both counters are all 0.
REQ-029 When rst is asserted mid-sweep, the block shall abort with no done pulse, and the latched expected value is discarded.
REQ-030 After rst is released, the first start shall be accepted on the first rising edge at which it is sampled high.

Structure
REQ-031 Package gate_bist_pkg shall hold the state enum (IDLE/SWEEP/REPORT), the constant NUM_VEC=4 and the constant SETTLE_W=4.
REQ-032 The optional sub-module gate_bist_timer (loadable 4-bit down-counter with an expire flag) is the natural split; all other logic stays in gate_bist.

Verification
REQ-033 Scenario: DUT = NAND-built OR, expected=4'b1110, SETTLE=1, start pulse -> busy for 4 cycles, done in the 5th cycle, captured=1110, pass=1, fail_idx=0.
REQ-034 Scenario: same DUT, expected=4'b1000 (AND table) -> captured=1110, pass=0, fail_idx=1.
REQ-035 Scenario: SETTLE=3 -> each vector held 3 cycles (12 busy cycles), dut_y sampled on the 3rd cycle of each hold, done in cycle 13.
REQ-036 Scenario: start pulsed at sweep cycle 2 and again on the done cycle -> neither is accepted; exactly one done pulse results.
REQ-037 Scenario: rst asserted between clock edges during vector 10 -> all outputs 0 immediately and no done; a following start runs a clean full sweep.
REQ-038 Scenario: expected changed from 1110 to 0000 mid-sweep -> the result is still pass=1.
